ifetch_stage: RTL and testbench



---
 rtl/ifetch_stage.sv | 159 +++++++++++++++
 tb/tb_ifetch_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: single-outstanding imem read, small FIFO toward decode,
// flush on taken branch. A slot is reserved at launch so a response always fits.
module ifetch_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        br_taken,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_r;
  logic [31:0]   mem_instr_r [DEPTH];
  logic [31:0]   mem_pc_r    [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW:0]   count_r;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic [PW:0]   count_nxt_s;
  logic          launch_s;
  logic          push_s;
  logic          pop_s;
  logic          bypass_s;

  // Launch/push/pop decisions and next FIFO read pointer and occupancy
  always_comb begin
    launch_s     = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    launch_s = (state_r == IDLE) && !br_taken && (count_r < DEPTH_C);
    push_s   = (state_r == BUSY) && imem_ack && !br_taken;
    pop_s    = if_valid && id_ready && !br_taken;
    if (br_taken) begin
      rd_ptr_nxt_s = '0;
      count_nxt_s  = '0;
    end else begin
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (push_s && !pop_s) begin
        count_nxt_s = count_r + (PW+1)'(1);
      end else if (pop_s && !push_s) begin
        count_nxt_s = count_r - (PW+1)'(1);
      end else begin
        count_nxt_s = count_r;
      end
    end
    // The incoming response becomes the head directly when it lands on the read slot.
    bypass_s = push_s && (wr_ptr_r == rd_ptr_nxt_s);
  end

  assign pc_advance = launch_s;

  // Request FSM: holds imem_req/imem_addr until the matching ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            imem_addr <= pc_in;
            imem_req  <= 1'b1;
            state_r   <= BUSY;
          end else begin
            state_r   <= IDLE;
          end
        end
        BUSY: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state_r  <= IDLE;
          end else if (br_taken) begin
            state_r  <= DRAIN;
          end else begin
            state_r  <= BUSY;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state_r  <= IDLE;
          end else begin
            state_r  <= DRAIN;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  // FIFO storage, pointers and registered head outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_r[i] <= 32'd0;
        mem_pc_r[i]    <= 32'd0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      if_valid <= 1'b0;
      if_instr <= 32'd0;
      if_pc    <= 32'd0;
    end else begin
      if (push_s) begin
        mem_instr_r[wr_ptr_r] <= imem_rdata;
        mem_pc_r[wr_ptr_r]    <= imem_addr;
      end else begin
        mem_instr_r[wr_ptr_r] <= mem_instr_r[wr_ptr_r];
      end
      if (br_taken) begin
        wr_ptr_r <= '0;
      end else if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      if_valid <= (count_nxt_s != '0);
      if (bypass_s) begin
        if_instr <= imem_rdata;
        if_pc    <= imem_addr;
      end else begin
        if_instr <= mem_instr_r[rd_ptr_nxt_s];
        if_pc    <= mem_pc_r[rd_ptr_nxt_s];
      end
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage (DEPTH=2): latency, backpressure, slow memory,
// branch flush in BUSY/at ack, and reset mid-transaction.
module tb_ifetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        br_taken;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ifetch_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .br_taken(br_taken),
    .pc_advance(pc_advance), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; br_taken = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0; pc_in = 32'h0000_8000; br_taken = 1'b0; imem_ack = 1'b0;
    imem_rdata = 32'd0; id_ready = 1'b1;
    tick();
    // Reset values
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);

    // 1: minimum latency
    rst = 1'b1; #1;
    chk("s1_adv0", {31'd0, pc_advance}, 32'd1);
    tick();
    chk("s1_req", {31'd0, imem_req}, 32'd1);
    chk("s1_addr", imem_addr, 32'h0000_8000);
    chk("s1_adv_busy", {31'd0, pc_advance}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_ack = 1'b0;
    chk("s1_valid", {31'd0, if_valid}, 32'd1);
    chk("s1_pc", if_pc, 32'h0000_8000);
    chk("s1_instr", if_instr, 32'h1111_1111);
    chk("s1_req_off", {31'd0, imem_req}, 32'd0);

    // 2: backpressure fills FIFO, then drains in order
    id_ready = 1'b0; pc_in = 32'h0000_8000;
    do_reset();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hA000_0000;
    tick();
    imem_ack = 1'b0; pc_in = 32'h0000_8004; #1;
    chk("s2_adv_second", {31'd0, pc_advance}, 32'd1);
    tick();
    chk("s2_addr2", imem_addr, 32'h0000_8004);
    imem_ack = 1'b1; imem_rdata = 32'hA000_0001;
    tick();
    imem_ack = 1'b0; #1;
    chk("s2_adv_full", {31'd0, pc_advance}, 32'd0);
    chk("s2_head_pc", if_pc, 32'h0000_8000);
    chk("s2_head_instr", if_instr, 32'hA000_0000);
    tick();
    chk("s2_no_req3", {31'd0, imem_req}, 32'd0);
    chk("s2_adv_full2", {31'd0, pc_advance}, 32'd0);
    chk("s2_head_stable", if_pc, 32'h0000_8000);
    id_ready = 1'b1;
    tick();
    chk("s2_pop1_valid", {31'd0, if_valid}, 32'd1);
    chk("s2_pop1_pc", if_pc, 32'h0000_8004);
    chk("s2_pop1_instr", if_instr, 32'hA000_0001);
    pc_in = 32'h0000_8008; #1;
    chk("s2_adv_resume", {31'd0, pc_advance}, 32'd1);
    tick();
    chk("s2_empty", {31'd0, if_valid}, 32'd0);
    chk("s2_req_resume", {31'd0, imem_req}, 32'd1);
    chk("s2_addr_resume", imem_addr, 32'h0000_8008);

    // 3: three-cycle memory latency
    pc_in = 32'h0000_C000;
    do_reset();
    tick();
    pc_in = 32'h0000_C004;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("s3_req", {31'd0, imem_req}, 32'd1);
      chk("s3_addr", imem_addr, 32'h0000_C000);
      chk("s3_adv", {31'd0, pc_advance}, 32'd0);
      if (c == 2) begin
        imem_ack = 1'b1; imem_rdata = 32'hB333_0000;
      end
      tick();
    end
    imem_ack = 1'b0;
    chk("s3_valid", {31'd0, if_valid}, 32'd1);
    chk("s3_pc", if_pc, 32'h0000_C000);
    chk("s3_instr", if_instr, 32'hB333_0000);

    // 4: branch while BUSY, response two cycles later is dropped
    pc_in = 32'h0000_1000;
    do_reset();
    tick();
    br_taken = 1'b1; pc_in = 32'h0000_2000; #1;
    chk("s4_adv_br", {31'd0, pc_advance}, 32'd0);
    tick();
    br_taken = 1'b0; #1;
    chk("s4_drain_req", {31'd0, imem_req}, 32'd1);
    chk("s4_drain_addr", imem_addr, 32'h0000_1000);
    chk("s4_drain_adv", {31'd0, pc_advance}, 32'd0);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0; #1;
    chk("s4_drop_valid", {31'd0, if_valid}, 32'd0);
    chk("s4_drop_req", {31'd0, imem_req}, 32'd0);
    chk("s4_adv_target", {31'd0, pc_advance}, 32'd1);
    tick();
    chk("s4_tgt_addr", imem_addr, 32'h0000_2000);
    chk("s4_no_stale", {31'd0, if_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_ack = 1'b0;
    chk("s4_tgt_pc", if_pc, 32'h0000_2000);
    chk("s4_tgt_instr", if_instr, 32'h2222_2222);

    // 5: branch coincident with ack, one entry buffered
    id_ready = 1'b0; pc_in = 32'h0000_3000;
    do_reset();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h3000_0030;
    tick();
    imem_ack = 1'b0; pc_in = 32'h0000_3004;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h3000_0031; br_taken = 1'b1; pc_in = 32'h0000_4000; #1;
    chk("s5_adv_br", {31'd0, pc_advance}, 32'd0);
    tick();
    imem_ack = 1'b0; br_taken = 1'b0; #1;
    chk("s5_valid", {31'd0, if_valid}, 32'd0);
    chk("s5_req", {31'd0, imem_req}, 32'd0);
    chk("s5_adv", {31'd0, pc_advance}, 32'd1);
    tick();
    chk("s5_relaunch_req", {31'd0, imem_req}, 32'd1);
    chk("s5_relaunch_addr", imem_addr, 32'h0000_4000);
    chk("s5_relaunch_valid", {31'd0, if_valid}, 32'd0);

    // 6: reset mid-transaction, stray ack ignored
    id_ready = 1'b0; pc_in = 32'h0000_5000;
    do_reset();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h5000_0050;
    tick();
    imem_ack = 1'b0; pc_in = 32'h0000_5004;
    tick();
    chk("s6_pre_req", {31'd0, imem_req}, 32'd1);
    chk("s6_pre_valid", {31'd0, if_valid}, 32'd1);
    rst = 1'b0; #1;
    chk("s6_rst_req", {31'd0, imem_req}, 32'd0);
    chk("s6_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("s6_rst_pc", if_pc, 32'd0);
    tick();
    rst = 1'b1; pc_in = 32'h0000_6000; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; #1;
    chk("s6_adv", {31'd0, pc_advance}, 32'd1);
    tick();
    chk("s6_stray_valid", {31'd0, if_valid}, 32'd0);
    chk("s6_addr", imem_addr, 32'h0000_6000);
    imem_rdata = 32'h6000_0060;
    tick();
    imem_ack = 1'b0;
    chk("s6_valid", {31'd0, if_valid}, 32'd1);
    chk("s6_pc", if_pc, 32'h0000_6000);
    chk("s6_instr", if_instr, 32'h6000_0060);
    id_ready = 1'b1;
    tick();
    chk("s6_drained", {31'd0, if_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
